rotator_arbiter: RTL
====================

ROTATOR_ARBITER -- requirements
Module: rotator_arbiter

Interface
REQ-001 Parameter: DW, 4, operand width; SHALL be 4; other values unsupported.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: req0  input  1  requester 0 operation request.
REQ-005 Port: data0  input  4  requester 0 operand.
REQ-006 Port: amt0  input  2  requester 0 rotate amount.
REQ-007 Port: ack0  output  1  one-cycle pulse; requester 0 operands captured.
REQ-008 Port: req1  input  1  requester 1 operation request.
REQ-009 Port: data1  input  4  requester 1 operand.
REQ-010 Port: amt1  input  2  requester 1 rotate amount.
REQ-011 Port: ack1  output  1  one-cycle pulse; requester 1 operands captured.
REQ-012 Port: res  output  4  registered rotate result.
REQ-013 Port: res_valid  output  1  res and res_id valid.
REQ-014 Port: res_id  output  1  requester index that owns res.
REQ-015 Port: res_ready  input  1  consumer accepts result.
REQ-016 Port: busy  output  1  high in any state except IDLE.

Function
REQ-017 The block SHALL share one 4-bit rotator between two requesters via an FSM with states IDLE, EXEC, DONE.
REQ-018 Rotation SHALL be left-rotate: res[i] = operand[(i - amt) mod 4]; amt=0 passes operand unchanged.
REQ-019 IDLE: if req0 or req1 high, arbiter SHALL select one grant, pulse matching ack for exactly that cycle, capture its data/amt and index, and go to EXEC; else stay IDLE.
REQ-020 EXEC: block SHALL rotate captured operands, register into res, set res_id, assert res_valid, go to DONE; lasts exactly one cycle.
REQ-021 DONE: res, res_id, res_valid=1 SHALL hold stable until a cycle with res_ready=1; then go to IDLE, res_valid=0 next cycle.
REQ-022 Latency: result SHALL be visible (res_valid=1) two cycles after the ack cycle edge; minimum issue interval 3 cycles.
REQ-023 No ack SHALL be issued outside IDLE; requests held during EXEC/DONE wait, are never dropped or double-acked.
REQ-024 res_ready in IDLE or EXEC SHALL be ignored.
REQ-025 Both req0 and req1 high in IDLE SHALL grant per REQ-030/REQ-031; exactly one ack SHALL pulse.
REQ-026 Operands SHALL be sampled only in the ack cycle; later changes to dataN/amtN SHALL not affect res.
REQ-027 res SHALL retain its last value in IDLE (res_valid=0).

Reset
REQ-028 rst high SHALL immediately force IDLE, ack0=ack1=0, res=0, res_id=0, res_valid=0, busy=0, round-robin pointer to favour requester 0, independent of clk.
REQ-029 Reset during EXEC or DONE SHALL discard the in-flight operation; no result delivered after rst deasserts.

Configuration
REQ-030 With ROT_RR_EN defined: round-robin; on contention the requester not served last SHALL win; pointer SHALL update on each completed handshake in DONE (to the served index).
REQ-031 Without ROT_RR_EN: fixed priority; requester 0 SHALL always win contention; no pointer register.

Verification
REQ-032 Single: req0=1, data0=4'b0001, amt0=2 -> ack0 pulse in cycle T, res=4'b0100, res_id=0, res_valid=1 at T+2.
REQ-033 Backpressure: res_ready=0 for 5 cycles in DONE -> res/res_valid stable 5 cycles; res_ready=1 -> res_valid=0 next cycle, busy=0.
REQ-034 Contention with ROT_RR_EN: req0=req1=1 continuously -> acks alternate 0,1,0,1; without macro -> ack0 only.
REQ-035 Wrap: data1=4'b1000, amt1=1 -> res=4'b0001; amt1=3 -> res=4'b0100; amt1=0 -> res=4'b1000.
REQ-036 Reset mid-op: assert rst during EXEC -> res_valid=0, res=0, busy=0 asynchronously; after deassert with req0=req1=1 -> requester 0 granted first.
REQ-037 Operand hold: change data0 the cycle after ack0 -> res reflects originally captured data0.

Source files
------------

// File: rtl/rotator_arbiter.sv
// Two-requester arbiter sharing one 4-bit left rotator through an IDLE/EXEC/DONE FSM.
// Define ROT_RR_EN for round-robin arbitration; the default build uses fixed priority (requester 0 wins).
`default_nettype none

module rotator_arbiter #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [DW-1:0] data0,
  input  logic [1:0]    amt0,
  output logic          ack0,
  input  logic          req1,
  input  logic [DW-1:0] data1,
  input  logic [1:0]    amt1,
  output logic          ack1,
  output logic [DW-1:0] res,
  output logic          res_valid,
  output logic          res_id,
  input  logic          res_ready,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] cap_data;
  logic [1:0]    cap_amt;
  logic          cap_id;
  logic          grant_any;
  logic          grant_id;
  logic [DW-1:0] rot;

  assign grant_any = req0 | req1;

`ifdef ROT_RR_EN
  // Index of the requester served last; reset to 1 so requester 0 wins first.
  logic last_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_id <= 1'b1;
    end else if (state == DONE && res_ready) begin
      last_id <= cap_id;
    end
  end

  always_comb begin
    grant_id = ~req0;
    if (req0 && req1) begin
      grant_id = ~last_id;
    end
  end
`else
  always_comb begin
    grant_id = ~req0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Acks are decoded in the IDLE cycle itself and gated by rst so they drop immediately.
  always_comb begin
    state_nxt = state;
    ack0      = 1'b0;
    ack1      = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any && !rst) begin
          ack0      = ~grant_id;
          ack1      = grant_id;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_data <= '0;
      cap_amt  <= 2'd0;
      cap_id   <= 1'b0;
    end else if (state == IDLE && grant_any) begin
      cap_data <= grant_id ? data1 : data0;
      cap_amt  <= grant_id ? amt1 : amt0;
      cap_id   <= grant_id;
    end
  end

  always_comb begin
    rot = cap_data;
    case (cap_amt)
      2'd0:    rot = cap_data;
      2'd1:    rot = {cap_data[DW-2:0], cap_data[DW-1]};
      2'd2:    rot = {cap_data[DW-3:0], cap_data[DW-1:DW-2]};
      2'd3:    rot = {cap_data[DW-4:0], cap_data[DW-1:DW-3]};
      default: rot = cap_data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res    <= '0;
      res_id <= 1'b0;
    end else if (state == EXEC) begin
      res    <= rot;
      res_id <= cap_id;
    end
  end

  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

`default_nettype wire
